// File: rtl/fp_unpack_pkg.sv
// Shared constants and types for the fp_unpack operand front end.
// Field widths, exponent limits, one-hot class bit indices and FSM encodings.
package fp_unpack_pkg;

  localparam int NEXP = 8;
  localparam int NSIG = 23;
  localparam int NW   = NEXP + NSIG + 1;
  localparam int EW   = NEXP + 2;

  localparam int BIAS = 2 ** (NEXP - 1) - 1;
  localparam int EMIN = 1 - BIAS;
  localparam int EMAX = BIAS;

  // Exponent constants at the width of the exp register.
  localparam logic signed [EW-1:0] EXP_SPECIAL = EW'(EMAX + 1);
  localparam logic signed [EW-1:0] EXP_MIN     = EW'(EMIN);
  localparam logic signed [EW-1:0] EXP_BIAS    = EW'(BIAS);
  localparam logic signed [EW-1:0] EXP_ONE     = EW'(1);

  // One-hot fclass bit positions: {sNaN,qNaN,inf,normal,subnormal,zero}.
  localparam int CLS_ZERO   = 0;
  localparam int CLS_SUB    = 1;
  localparam int CLS_NORMAL = 2;
  localparam int CLS_INF    = 3;
  localparam int CLS_QNAN   = 4;
  localparam int CLS_SNAN   = 5;
  localparam int NCLS       = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fp_unpack_if.sv
// Operand-in / decoded-result-out handshake bundle for fp_unpack.
// master = producer of operands and consumer of results; slave = fp_unpack.
interface fp_unpack_if;
  import fp_unpack_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [NW-1:0]        in_bits;
  logic                 out_valid;
  logic                 out_ready;
  logic                 neg;
  logic signed [EW-1:0] exp;
  logic [NSIG:0]        sig;
  logic [NCLS-1:0]      fclass;

  modport master (
    output in_valid, in_bits, out_ready,
    input  in_ready, out_valid, neg, exp, sig, fclass
  );

  modport slave (
    input  in_valid, in_bits, out_ready,
    output in_ready, out_valid, neg, exp, sig, fclass
  );

endinterface

// File: rtl/fp_classify.sv
// Combinational IEEE-754 classifier: {exponent field, fraction} -> one-hot class.
// With FP_UNPACK_DAZ_EN defined, subnormal encodings are reported as zero.
module fp_classify
  import fp_unpack_pkg::*;
(
  input  logic [NEXP-1:0] e,
  input  logic [NSIG-1:0] f,
  output logic [NCLS-1:0] cls
);

  logic e_max;
  logic e_zero;
  logic f_zero;

  assign e_max  = &e;
  assign e_zero = ~|e;
  assign f_zero = ~|f;

  // Exactly one class bit is set for every encoding.
  always_comb begin
    cls = '0;
    if (e_max) begin
      if (f_zero)        cls[CLS_INF]  = 1'b1;
      else if (f[NSIG-1]) cls[CLS_QNAN] = 1'b1;
      else               cls[CLS_SNAN] = 1'b1;
    end else if (e_zero) begin
`ifdef FP_UNPACK_DAZ_EN
      cls[CLS_ZERO] = 1'b1;
`else
      if (f_zero) cls[CLS_ZERO] = 1'b1;
      else        cls[CLS_SUB]  = 1'b1;
`endif
    end else begin
      cls[CLS_NORMAL] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_unpack.sv
// fp_unpack: decodes one IEEE-754 operand into sign, unbiased exponent and
// explicit-leading-one significand, plus a one-hot class.
// Subnormals are normalized one bit per clock in NORM.
// Macro FP_UNPACK_DAZ_EN: subnormals are flushed to zero and NORM is removed.
//
// state  | meaning
// IDLE   | waiting for an operand, in_ready=1
// NORM   | shifting a subnormal significand left until the leading one lands
// DONE   | result presented, held until out_ready
module fp_unpack
  import fp_unpack_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  fp_unpack_if.slave bus
);

  state_t               state_q, state_d;
  logic                 neg_q, neg_d;
  logic signed [EW-1:0] exp_q, exp_d;
  logic [NSIG:0]        sig_q, sig_d;
  logic [NCLS-1:0]      cls_q, cls_d;

  logic                 in_neg;
  logic [NEXP-1:0]      in_e;
  logic [NSIG-1:0]      in_f;
  logic [NCLS-1:0]      in_cls;
  logic                 accept;

  assign {in_neg, in_e, in_f} = bus.in_bits;
  assign accept = bus.in_valid & bus.in_ready;

  fp_classify u_classify (
    .e   (in_e),
    .f   (in_f),
    .cls (in_cls)
  );

  // Next-state, decode at accept and the normalization shift.
  always_comb begin
    state_d = state_q;
    neg_d   = neg_q;
    exp_d   = exp_q;
    sig_d   = sig_q;
    cls_d   = cls_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          neg_d   = in_neg;
          cls_d   = in_cls;
          state_d = S_DONE;
          if (in_e == '1) begin
            // inf and NaN keep the payload behind the explicit one
            exp_d = EXP_SPECIAL;
            sig_d = {1'b1, in_f};
          end else if (in_e == '0) begin
            exp_d = EXP_MIN;
            sig_d = '0;
`ifndef FP_UNPACK_DAZ_EN
            if (in_f != '0) begin
              sig_d   = {1'b0, in_f};
              state_d = S_NORM;
            end
`endif
          end else begin
            exp_d = $signed({2'b00, in_e}) - EXP_BIAS;
            sig_d = {1'b1, in_f};
          end
        end
      end
`ifndef FP_UNPACK_DAZ_EN
      S_NORM: begin
        sig_d = sig_q << 1;
        exp_d = exp_q - EXP_ONE;
        // the bit about to move into the leading position decides the exit
        if (sig_q[NSIG-1]) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset aborts any operand in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      neg_q   <= 1'b0;
      exp_q   <= '0;
      sig_q   <= '0;
      cls_q   <= '0;
    end else begin
      state_q <= state_d;
      neg_q   <= neg_d;
      exp_q   <= exp_d;
      sig_q   <= sig_d;
      cls_q   <= cls_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.neg       = neg_q;
  assign bus.exp       = exp_q;
  assign bus.sig       = sig_q;
  assign bus.fclass    = cls_q;

endmodule

// File: tb/tb_fp_unpack.sv
// Directed, table-driven bench for fp_unpack (NEXP=8, NSIG=23).
module tb_fp_unpack;

  logic clk;
  logic rst;

  fp_unpack_if bus ();

  fp_unpack dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] C_ZERO = 6'b000001;
  localparam logic [5:0] C_SUB  = 6'b000010;
  localparam logic [5:0] C_NORM = 6'b000100;
  localparam logic [5:0] C_INF  = 6'b001000;
  localparam logic [5:0] C_QNAN = 6'b010000;
  localparam logic [5:0] C_SNAN = 6'b100000;

  typedef struct {
    logic [31:0] word;
    logic        neg;
    int          exp;
    logic [23:0] sig;
    logic [5:0]  cls;
    int          lat;
  } vec_t;

  vec_t vecs[12];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand with out_ready=1, measure latency, check the result
  // and let the handshake return the block to IDLE.
  task automatic run_vec(input vec_t v);
    int lat;
    bit busy_err;
    chk("in_ready_before", bus.in_ready, 1);
    bus.in_bits  = v.word;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    busy_err = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) busy_err = 1'b1;
      tick();
      lat++;
    end
    chk($sformatf("lat_%08h", v.word), lat, v.lat);
    chk($sformatf("busy_%08h", v.word), busy_err, 0);
    chk($sformatf("neg_%08h", v.word), bus.neg, v.neg);
    chk($sformatf("exp_%08h", v.word), int'(bus.exp), v.exp);
    chk($sformatf("sig_%08h", v.word), bus.sig, v.sig);
    chk($sformatf("cls_%08h", v.word), bus.fclass, v.cls);
    tick();
    chk($sformatf("drain_%08h", v.word), bus.out_valid, 0);
  endtask

  initial begin
    vec_t v;
    bit   seen;
    logic        h_neg;
    int          h_exp;
    logic [23:0] h_sig;
    logic [5:0]  h_cls;

    vecs[0]  = '{32'h3F800000, 1'b0,    0, 24'h800000, C_NORM, 1};
`ifdef FP_UNPACK_DAZ_EN
    vecs[1]  = '{32'h00000001, 1'b0, -126, 24'h000000, C_ZERO, 1};
    vecs[6]  = '{32'h00400000, 1'b0, -126, 24'h000000, C_ZERO, 1};
    vecs[9]  = '{32'h807FFFFF, 1'b1, -126, 24'h000000, C_ZERO, 1};
    vecs[10] = '{32'h00000300, 1'b0, -126, 24'h000000, C_ZERO, 1};
`else
    vecs[1]  = '{32'h00000001, 1'b0, -149, 24'h800000, C_SUB, 24};
    vecs[6]  = '{32'h00400000, 1'b0, -127, 24'h800000, C_SUB, 2};
    vecs[9]  = '{32'h807FFFFF, 1'b1, -127, 24'hFFFFFE, C_SUB, 2};
    vecs[10] = '{32'h00000300, 1'b0, -140, 24'hC00000, C_SUB, 15};
`endif
    vecs[2]  = '{32'hFF800000, 1'b1,  128, 24'h800000, C_INF,  1};
    vecs[3]  = '{32'h7FC00000, 1'b0,  128, 24'hC00000, C_QNAN, 1};
    vecs[4]  = '{32'h7F800001, 1'b0,  128, 24'h800001, C_SNAN, 1};
    vecs[5]  = '{32'h80000000, 1'b1, -126, 24'h000000, C_ZERO, 1};
    vecs[7]  = '{32'h7F7FFFFF, 1'b0,  127, 24'hFFFFFF, C_NORM, 1};
    vecs[8]  = '{32'h00800000, 1'b0, -126, 24'h800000, C_NORM, 1};
    vecs[11] = '{32'hC0490FDB, 1'b1,    1, 24'hC90FDB, C_NORM, 1};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_bits   = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_neg", bus.neg, 0);
    chk("rst_exp", int'(bus.exp), 0);
    chk("rst_sig", bus.sig, 0);
    chk("rst_fclass", bus.fclass, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Backpressure: result held for 5 cycles while a new operand is offered.
    bus.out_ready = 1'b0;
    bus.in_bits   = 32'h40000000;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_bits   = 32'h3F800000;
    chk("bp_valid", bus.out_valid, 1);
    h_neg = 1'b0;
    h_exp = 1;
    h_sig = 24'h800000;
    h_cls = C_NORM;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp_hold_valid_%0d", c), bus.out_valid, 1);
      chk($sformatf("bp_hold_ready_%0d", c), bus.in_ready, 0);
      chk($sformatf("bp_hold_exp_%0d", c), int'(bus.exp), h_exp);
      chk($sformatf("bp_hold_sig_%0d", c), bus.sig, h_sig);
      chk($sformatf("bp_hold_cls_%0d", c), bus.fclass, h_cls);
      chk($sformatf("bp_hold_neg_%0d", c), bus.neg, h_neg);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_valid", bus.out_valid, 0);
    chk("bp_release_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_next_valid", bus.out_valid, 1);
    chk("bp_next_exp", int'(bus.exp), 0);
    chk("bp_next_cls", bus.fclass, C_NORM);
    tick();
    chk("bp_next_drain", bus.out_valid, 0);

    // Reset in the middle of normalizing 0x00000001 (or just after accept with DAZ).
    bus.in_bits  = 32'h00000001;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
`ifndef FP_UNPACK_DAZ_EN
    for (int c = 0; c < 5; c++) tick();
    chk("mid_norm_busy", bus.in_ready, 0);
`endif
    rst = 1'b1;
    #1;
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_ready", bus.in_ready, 1);
    chk("abort_exp", int'(bus.exp), 0);
    chk("abort_sig", bus.sig, 0);
    chk("abort_cls", bus.fclass, 0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    chk("abort_no_emit", seen, 0);
    v = vecs[0];
    run_vec(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
